// File: rtl/pc_stack_seq.sv
// Program-counter sequencer with a hardware return-address stack, stall,
// sticky halt/error flags and a saturating executed-cycle counter.
module pc_stack_seq #(
    parameter int PCW   = 10,
    parameter int DEPTH = 4,
    parameter int CTW   = 16
) (
    input  logic                       CLK,
    input  logic                       start,
    input  logic                       stall,
    input  logic                       jump_en,
    input  logic                       branch_en,
    input  logic                       cond,
    input  logic                       call_en,
    input  logic                       ret_en,
    input  logic                       halt_req,
    input  logic [PCW-1:0]             destination,
    output logic [PCW-1:0]             PC,
    output logic                       halt,
    output logic                       stack_err,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [CTW-1:0]             cycle_ct
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0]  DEPTH_FULL = DW'(DEPTH);
    localparam logic [CTW-1:0] CT_MAX     = '1;

    logic [PCW-1:0] stack_mem [DEPTH];

    logic [PCW-1:0] pc_next;
    logic [PCW-1:0] pc_inc;
    logic           halt_next;
    logic           err_next;
    logic [DW-1:0]  depth_next;
    logic [CTW-1:0] ct_next;
    logic           push;
    logic [AW-1:0]  push_idx;
    logic [AW-1:0]  pop_idx;

    assign pc_inc   = PC + PCW'(1);
    assign push_idx = AW'(depth);
    assign pop_idx  = AW'(depth - DW'(1));

    // Request arbitration: halt freezes everything, stall freezes PC and stack
    // but still lets the cycle counter advance.
    always_comb begin
        pc_next    = PC;
        halt_next  = halt;
        err_next   = stack_err;
        depth_next = depth;
        ct_next    = cycle_ct;
        push       = 1'b0;
        if (!halt) begin
            ct_next = (cycle_ct == CT_MAX) ? cycle_ct : cycle_ct + CTW'(1);
            if (!stall) begin
                if (halt_req) begin
                    halt_next = 1'b1;
                end else if (ret_en) begin
                    if (depth == '0) begin
                        err_next  = 1'b1;
                        halt_next = 1'b1;
                    end else begin
                        pc_next    = stack_mem[pop_idx];
                        depth_next = depth - DW'(1);
                    end
                end else if (call_en) begin
                    if (depth == DEPTH_FULL) begin
                        err_next  = 1'b1;
                        halt_next = 1'b1;
                    end else begin
                        push       = 1'b1;
                        depth_next = depth + DW'(1);
                        pc_next    = destination;
                    end
                end else if (jump_en || (branch_en && cond)) begin
                    pc_next = destination;
                end else begin
                    pc_next = pc_inc;
                end
            end
        end
    end

    // Stack contents are never reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (start) begin
            PC        <= '0;
            halt      <= 1'b0;
            stack_err <= 1'b0;
            depth     <= '0;
            cycle_ct  <= '0;
        end else begin
            PC        <= pc_next;
            halt      <= halt_next;
            stack_err <= err_next;
            depth     <= depth_next;
            cycle_ct  <= ct_next;
            if (push) begin
                stack_mem[push_idx] <= pc_inc;
            end
        end
    end

endmodule

// File: tb/tb_pc_stack_seq.sv
// Randomised and directed bench for pc_stack_seq: a queue-based reference model
// predicts each cycle's outputs and a separate monitor checks them.
module tb_pc_stack_seq;

    localparam int PCW   = 7;
    localparam int DEPTH = 4;
    localparam int CTW   = 5;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int PCMOD = 1 << PCW;
    localparam int CTMAX = (1 << CTW) - 1;

    logic           CLK = 1'b0;
    logic           start = 1'b1;
    logic           stall = 1'b0;
    logic           jump_en = 1'b0;
    logic           branch_en = 1'b0;
    logic           cond = 1'b0;
    logic           call_en = 1'b0;
    logic           ret_en = 1'b0;
    logic           halt_req = 1'b0;
    logic [PCW-1:0] destination = '0;
    logic [PCW-1:0] PC;
    logic           halt;
    logic           stack_err;
    logic [DW-1:0]  depth;
    logic [CTW-1:0] cycle_ct;

    pc_stack_seq #(.PCW(PCW), .DEPTH(DEPTH), .CTW(CTW)) dut (
        .CLK(CLK), .start(start), .stall(stall), .jump_en(jump_en),
        .branch_en(branch_en), .cond(cond), .call_en(call_en), .ret_en(ret_en),
        .halt_req(halt_req), .destination(destination), .PC(PC), .halt(halt),
        .stack_err(stack_err), .depth(depth), .cycle_ct(cycle_ct)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int pc;
        bit halt;
        bit err;
        int depth;
        int ct;
    } expect_t;

    expect_t exp_q[$];
    int      vectors = 0;
    int      miscompares = 0;

    int m_pc = 0;
    bit m_halt = 0;
    bit m_err = 0;
    int m_ct = 0;
    int m_stack[$];

    // Reference model: the return stack is a plain queue, PC arithmetic is modular.
    function automatic void model_step(bit st, bit sl, bit j, bit b, bit c,
                                       bit ca, bit r, bit h, int dest);
        if (st) begin
            m_pc = 0; m_halt = 0; m_err = 0; m_ct = 0;
            m_stack.delete();
        end else if (!m_halt) begin
            if (m_ct < CTMAX) m_ct++;
            if (!sl) begin
                if (h) m_halt = 1;
                else if (r) begin
                    if (m_stack.size() == 0) begin m_err = 1; m_halt = 1; end
                    else m_pc = m_stack.pop_back();
                end else if (ca) begin
                    if (m_stack.size() == DEPTH) begin m_err = 1; m_halt = 1; end
                    else begin m_stack.push_back((m_pc + 1) % PCMOD); m_pc = dest; end
                end else if (j || (b && c)) m_pc = dest;
                else m_pc = (m_pc + 1) % PCMOD;
            end
        end
    endfunction

    task automatic apply_stimulus(input bit st, input bit sl, input bit j, input bit b,
                                  input bit c, input bit ca, input bit r, input bit h,
                                  input int dest);
        expect_t e;
        start = st; stall = sl; jump_en = j; branch_en = b; cond = c;
        call_en = ca; ret_en = r; halt_req = h; destination = PCW'(dest);
        model_step(st, sl, j, b, c, ca, r, h, dest);
        e.pc = m_pc; e.halt = m_halt; e.err = m_err;
        e.depth = m_stack.size(); e.ct = m_ct;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input int expv);
        if (act !== expv[31:0]) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: every cycle presents a fresh output set, checked mid-cycle.
    initial begin
        expect_t e;
        forever begin
            @(posedge CLK);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                check_output("pc", 32'(PC), e.pc);
                check_output("halt", 32'(halt), int'(e.halt));
                check_output("stack_err", 32'(stack_err), int'(e.err));
                check_output("depth", 32'(depth), e.depth);
                check_output("cycle_ct", 32'(cycle_ct), e.ct);
            end
        end
    end

    initial begin
        bit st, sl, j, b, c, ca, r, h;
        // Sequential run, then call/return round trip from PC=7.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(7);
        apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, 'h40);
        idle(2);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);

        // Branch not taken / taken, jump+call priority, stall swallowing a jump.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        apply_stimulus(0, 0, 0, 1, 0, 0, 0, 0, 'h30);
        apply_stimulus(0, 0, 0, 1, 1, 0, 0, 0, 'h20);
        apply_stimulus(0, 0, 1, 0, 0, 1, 0, 0, 'h35);
        apply_stimulus(0, 1, 1, 0, 0, 0, 0, 0, 'h50);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);

        // Nested calls overflow, stay frozen, then restart.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEPTH + 1; i++) apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0, i * 16);
        idle(3);
        apply_stimulus(0, 1, 1, 0, 0, 0, 0, 0, 5);

        // Return with an empty stack, then start clears everything.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Halt request at 0x12, then a long run that wraps PC and saturates the counter.
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 'h12);
        apply_stimulus(0, 0, 1, 0, 0, 1, 1, 1, 'h33);
        idle(3);
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(PCMOD + 3);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);

        for (int n = 0; n < 800; n++) begin
            st = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) < 2);
            sl = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 3) == 0);
            c  = 1'($urandom_range(0, 1));
            ca = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 4) == 0);
            h  = ($urandom_range(0, 39) == 0);
            apply_stimulus(st, sl, j, b, c, ca, r, h, int'($urandom_range(0, PCMOD - 1)));
        end
        idle(2);

        repeat (3) @(posedge CLK);
        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
